w_input_conditioner: RTL and testbench
======================================

Name: w_input_conditioner

Overview:
Upstream stage of the ej2 Moore machine. It takes the raw asynchronous W input from a switch or button and produces the clean serial bit outputW that feeds the next-state logic. It also produces outputStep, a one-cycle enable that tells the state register when to load Y1..Y3.
- Internals: 2-FF synchronizer, 4-state debounce FSM, tick divider.

Parameters:
- DEBOUNCE_CYCLES, 4, number of consecutive synchronized cycles the input must differ from outputW before outputW flips (legal range >= 1).
- TICK_DIV, 8, clock cycles per outputStep pulse (legal range >= 1).

Ports:
- clock  input  1  system clock; every flop updates on the rising edge.
- reset  input  1  synchronous, active-high reset.
- inputRaw  input  1  asynchronous raw W from a switch or button.
- inputEnable  input  1  when high, the tick divider runs; when low, it holds.
- outputW  output  1  debounced W, registered; this is the W input of the next-state logic.
- outputEdge  output  1  one-cycle pulse when outputW changes value.
- outputStep  output  1  one-cycle state-register load enable.

Behaviour:
- Clocking and reset: one clock domain. Reset is synchronous and active-high. It is sampled on the clock edge and takes priority over all other logic.
- Reset values: sync flops 0, FSM in S0, debounce counter 0, tick counter 0, outputW 0, outputEdge 0, outputStep 0.
- Reset mid-operation: any pending debounce is discarded, outputW returns to 0 and the tick phase restarts.
- Synchronizer: sync1 <= inputRaw, sync2 <= sync1. Only sync2 is used downstream.
- FSM states:
  - S0: stable low.
  - P1: pending high.
  - S1: stable high.
  - P0: pending low.
- Transitions, with cnt counting consecutive cycles where sync2 differs from outputW:
  - S0 & sync2=1 -> P1, cnt=1.
  - P1 & sync2=0 -> S0, cnt=0 (glitch rejected).
  - P1 & sync2=1 & cnt<DEBOUNCE_CYCLES-1 -> cnt+1.
  - P1 & sync2=1 & cnt=DEBOUNCE_CYCLES-1 -> S1, cnt=0.
  - S1/P0: same rules with polarity swapped.
- DEBOUNCE_CYCLES=1: S0 & sync2=1 goes directly to S1. The pending states are unused.
- outputW = 1 in S1 and P0, 0 in S0 and P1. It is registered (state-decoded).
- Latency: let edge 0 be the first edge at which sync1 captures the new inputRaw level. If the level is held, outputW changes on edge DEBOUNCE_CYCLES+1 (edge 5 with the default).
- Glitch rejection: a pulse shorter than DEBOUNCE_CYCLES synchronized cycles never reaches outputW. Bouncing restarts the count from the last transition.
- outputEdge: high for exactly the one cycle following the edge on which outputW toggled. It is never high two cycles in a row.
- Tick divider: counter counts 0..TICK_DIV-1 and advances only when inputEnable=1.
  - When the counter is TICK_DIV-1 with inputEnable=1, the next edge wraps it to 0 and drives outputStep=1 for one cycle; otherwise outputStep=0.
  - The first pulse comes after edge TICK_DIV following reset release, with enable continuously high.
  - inputEnable=0 freezes the counter and forces outputStep=0 on the next edge.
  - TICK_DIV=1: outputStep=1 every cycle while enabled.
- Debounce and tick are independent. A W change coinciding with a step pulse is legal: the state register samples the outputW value present in that cycle.

Decomposition:
- Shared package ej2_pkg holds:
  - FSM state encoding constants S0/P1/S1/P0, 2 bits.
  - Default DEBOUNCE_CYCLES and TICK_DIV constants.
  - A clog2-based counter-width helper.
- Sub-module sync_2ff (1-bit, reset to 0) is natural, since the same synchronizer is reused on the other ej2 inputs.
- The FSM and the tick divider stay in this module.

Test Plan:
1. Hold reset 3 cycles with inputRaw=1 and inputEnable=1 -> outputW, outputEdge and outputStep are all 0 throughout; after release, outputW rises on edge DEBOUNCE_CYCLES+1 counted from the first capture.
2. Defaults; inputRaw 0->1, held (captured at edge 0) -> outputW=1 after edge 5; outputEdge=1 only in the cycle after edge 5. Then 1->0 -> symmetric fall 5 edges later.
3. inputRaw high for 3 cycles, then low -> outputW stays 0 and outputEdge never pulses.
4. Bounce pattern 1,1,0,1,1,1,1,1 from S0 -> the count restarts at the third sample; outputW rises only after 4 consecutive synchronized highs.
5. TICK_DIV=8, inputEnable=1 -> outputStep pulses after edges 8 and 16. Rerun with inputEnable=0 during edges 11-15 -> pulses after edges 8 and 21.
6. Reset asserted for one edge while in P1 with cnt=2 -> state S0, cnt 0, outputW 0; with inputRaw still high, a full DEBOUNCE_CYCLES+1 edges are needed before outputW rises.

Source files
------------

// File: rtl/ej2_pkg.sv
// ej2_pkg: shared encodings, default timing constants and width helper for the ej2 input stage
package ej2_pkg;

    // Debounce FSM encoding; bit 1 carries the debounced level in the stable/pending-opposite pair
    typedef enum logic [1:0] {
        S0 = 2'b00,
        P1 = 2'b01,
        S1 = 2'b11,
        P0 = 2'b10
    } state_t;

    localparam int DEFAULT_DEBOUNCE_CYCLES = 4;
    localparam int DEFAULT_TICK_DIV        = 8;

    // Counter width for a count of n states; never narrower than one bit
    function automatic int cnt_width(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/sync_2ff.sv
// sync_2ff: two-flop synchronizer for a single asynchronous bit
//   clock : system clock
//   reset : synchronous active-high reset, clears both flops
//   d     : asynchronous input
//   q     : synchronized output (second flop)
module sync_2ff (
    input  logic clock,
    input  logic reset,
    input  logic d,
    output logic q
);

    logic meta;

    always_ff @(posedge clock) begin
        if (reset) begin
            meta <= 1'b0;
            q    <= 1'b0;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/w_input_conditioner.sv
// w_input_conditioner: synchronizes, debounces and edge-detects raw W and generates the state-load tick
//   clock       : system clock
//   reset       : synchronous active-high reset
//   inputRaw    : asynchronous raw W
//   inputEnable : lets the tick divider advance
//   outputW     : debounced W, decoded from the registered FSM state
//   outputEdge  : one-cycle pulse after outputW changes
//   outputStep  : one-cycle state-register load enable every TICK_DIV enabled cycles
module w_input_conditioner
    import ej2_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES,
    parameter int TICK_DIV        = DEFAULT_TICK_DIV
) (
    input  logic clock,
    input  logic reset,
    input  logic inputRaw,
    input  logic inputEnable,
    output logic outputW,
    output logic outputEdge,
    output logic outputStep
);

    localparam int CW = cnt_width(DEBOUNCE_CYCLES);
    localparam int TW = cnt_width(TICK_DIV);
    localparam logic [CW-1:0] CNT_LAST  = CW'(DEBOUNCE_CYCLES - 1);
    localparam logic [TW-1:0] TICK_LAST = TW'(TICK_DIV - 1);

    logic          sync2;
    state_t        state, state_n;
    logic [CW-1:0] cnt, cnt_n;
    logic          w_n;
    logic [TW-1:0] tcnt;

    sync_2ff u_sync (
        .clock (clock),
        .reset (reset),
        .d     (inputRaw),
        .q     (sync2)
    );

    always_ff @(posedge clock) begin
        if (reset) begin
            state      <= S0;
            cnt        <= '0;
            outputEdge <= 1'b0;
        end else begin
            state      <= state_n;
            cnt        <= cnt_n;
            outputEdge <= w_n ^ outputW;
        end
    end

    // cnt holds how many consecutive samples have disagreed with outputW while pending
    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        case (state)
            S0: begin
                if (sync2) begin
                    state_n = (DEBOUNCE_CYCLES == 1) ? S1 : P1;
                    cnt_n   = (DEBOUNCE_CYCLES == 1) ? '0 : CW'(1);
                end
            end
            P1: begin
                if (!sync2) begin
                    state_n = S0;
                    cnt_n   = '0;
                end else if (cnt == CNT_LAST) begin
                    state_n = S1;
                    cnt_n   = '0;
                end else begin
                    cnt_n = cnt + CW'(1);
                end
            end
            S1: begin
                if (!sync2) begin
                    state_n = (DEBOUNCE_CYCLES == 1) ? S0 : P0;
                    cnt_n   = (DEBOUNCE_CYCLES == 1) ? '0 : CW'(1);
                end
            end
            P0: begin
                if (sync2) begin
                    state_n = S1;
                    cnt_n   = '0;
                end else if (cnt == CNT_LAST) begin
                    state_n = S0;
                    cnt_n   = '0;
                end else begin
                    cnt_n = cnt + CW'(1);
                end
            end
            default: begin
                state_n = S0;
                cnt_n   = '0;
            end
        endcase
    end

    assign outputW = (state == S1) || (state == P0);
    assign w_n     = (state_n == S1) || (state_n == P0);

    always_ff @(posedge clock) begin
        if (reset) begin
            tcnt       <= '0;
            outputStep <= 1'b0;
        end else begin
            outputStep <= inputEnable && (tcnt == TICK_LAST);
            if (inputEnable)
                tcnt <= (tcnt == TICK_LAST) ? '0 : tcnt + TW'(1);
        end
    end

endmodule

// File: tb/tb_w_input_conditioner.sv
// tb_w_input_conditioner: directed self-checking bench for w_input_conditioner with default parameters
module tb_w_input_conditioner;

    logic clock = 1'b0;
    logic reset;
    logic inputRaw;
    logic inputEnable;
    logic outputW;
    logic outputEdge;
    logic outputStep;

    int vectors = 0;
    int miscompares = 0;

    w_input_conditioner dut (
        .clock       (clock),
        .reset       (reset),
        .inputRaw    (inputRaw),
        .inputEnable (inputEnable),
        .outputW     (outputW),
        .outputEdge  (outputEdge),
        .outputStep  (outputStep)
    );

    always #5 clock = ~clock;

    task automatic clk_edge();
        @(posedge clock);
        @(negedge clock);
    endtask

    task automatic chk(input string tag, input int step, input logic obs, input logic exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s step %0d: got %b expected %b", tag, step, obs, exp);
        end
    endtask

    initial begin
        reset       = 1'b1;
        inputRaw    = 1'b1;
        inputEnable = 1'b1;
        for (int i = 1; i <= 3; i++) begin
            clk_edge();
            chk("rst_w", i, outputW, 1'b0);
            chk("rst_edge", i, outputEdge, 1'b0);
            chk("rst_step", i, outputStep, 1'b0);
        end
        reset = 1'b0;
        for (int p = 1; p <= 17; p++) begin
            clk_edge();
            chk("rise_w", p, outputW, p >= 6);
            chk("rise_edge", p, outputEdge, p == 6);
            chk("tick_step", p, outputStep, (p == 8) || (p == 16));
        end
        inputRaw = 1'b0;
        for (int d = 0; d <= 6; d++) begin
            clk_edge();
            chk("fall_w", d, outputW, d < 5);
            chk("fall_edge", d, outputEdge, d == 5);
        end
        inputRaw = 1'b1;
        for (int d = 0; d <= 9; d++) begin
            if (d == 3)
                inputRaw = 1'b0;
            clk_edge();
            chk("glitch_w", d, outputW, 1'b0);
            chk("glitch_edge", d, outputEdge, 1'b0);
        end
        for (int d = 0; d <= 9; d++) begin
            inputRaw = (d != 2);
            clk_edge();
            chk("bounce_w", d, outputW, d >= 8);
            chk("bounce_edge", d, outputEdge, d == 8);
        end
        inputRaw = 1'b0;
        reset    = 1'b1;
        clk_edge();
        chk("rst2_w", 0, outputW, 1'b0);
        chk("rst2_step", 0, outputStep, 1'b0);
        reset = 1'b0;
        for (int p = 1; p <= 22; p++) begin
            inputEnable = !((p >= 11) && (p <= 15));
            clk_edge();
            chk("hold_step", p, outputStep, (p == 8) || (p == 21));
        end
        inputEnable = 1'b1;
        inputRaw    = 1'b1;
        for (int d = 0; d <= 3; d++) begin
            clk_edge();
            chk("pend_w", d, outputW, 1'b0);
        end
        reset = 1'b1;
        clk_edge();
        chk("midrst_w", 0, outputW, 1'b0);
        chk("midrst_edge", 0, outputEdge, 1'b0);
        reset = 1'b0;
        for (int d = 0; d <= 6; d++) begin
            clk_edge();
            chk("post_rst_w", d, outputW, d >= 5);
            chk("post_rst_edge", d, outputEdge, d == 5);
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
